// File: rtl/corelet_pkg.sv
// -----------------------------------------------------------------------------
// corelet_pkg
// Shared definitions for the corelet datapath blocks.
//   COL      : columns (lanes) per psum vector
//   PSUM_BW  : bits per psum lane
//   ADDR_W   : psum SRAM address width
//   drain_state_t : psum_drain controller states
//   psum_vec_t    : one full psum vector (COL lanes, lane 0 in the LSBs)
// -----------------------------------------------------------------------------
package corelet_pkg;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int ADDR_W  = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

  typedef logic [PSUM_BW*COL-1:0] psum_vec_t;

endpackage

// File: rtl/psum_drain.sv
// -----------------------------------------------------------------------------
// psum_drain
// Read-side controller for the corelet OFIFO. After an accepted start it pops
// num_vec psum vectors from the OFIFO and writes each one, unmodified, to the
// psum SRAM at consecutive addresses starting at base_addr (wrapping modulo
// 2^ADDR_W). A start/done handshake returns control to the sequencer.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-low
//   start        in   1-cycle drain request, only honoured in IDLE
//   num_vec      in   vectors to drain (latched on accepted start)
//   base_addr    in   first SRAM address (latched on accepted start)
//   ofifo_valid  in   OFIFO holds at least one complete vector
//   ofifo_rd     out  pop request; data shows on psum_in the next cycle
//   psum_in      in   OFIFO output data
//   pmem_cen     out  SRAM chip enable, active-low
//   pmem_wen     out  SRAM write enable, active-low
//   pmem_addr    out  SRAM address
//   pmem_d       out  SRAM write data (holds last written vector when idle)
//   busy         out  high from the cycle after an accepted start until done
//   done         out  1-cycle pulse after the last SRAM write
//   checksum     out  only with PSUM_DRAIN_CHECKSUM_EN: XOR of every vector
//                     written since the last accepted start
//
// Optional feature macro: PSUM_DRAIN_CHECKSUM_EN
//
// Handshake: a pop happens in every cycle where ofifo_rd is high (the OFIFO
// must honour it, which it can since ofifo_rd implies ofifo_valid); the popped
// vector is presented on psum_in in the following cycle, and that same cycle
// is the SRAM write cycle (pmem_cen = pmem_wen = 0).
// -----------------------------------------------------------------------------
module psum_drain #(
  parameter int COL     = corelet_pkg::COL,
  parameter int PSUM_BW = corelet_pkg::PSUM_BW,
  parameter int ADDR_W  = corelet_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      num_vec,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic                   ofifo_valid,
  output logic                   ofifo_rd,
  input  logic [PSUM_BW*COL-1:0] psum_in,
  output logic                   pmem_cen,
  output logic                   pmem_wen,
  output logic [ADDR_W-1:0]      pmem_addr,
  output logic [PSUM_BW*COL-1:0] pmem_d,
  output logic                   busy,
  output logic                   done
`ifdef PSUM_DRAIN_CHECKSUM_EN
  ,
  output logic [PSUM_BW*COL-1:0] checksum
`endif
);

  import corelet_pkg::*;

  localparam int VW = PSUM_BW * COL;

  drain_state_t      state;
  logic [ADDR_W-1:0] num_q;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] rd_nxt;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_q;
  logic [VW-1:0]     d_hold;
  logic              pop;
  logic              wr_fire;
  logic              accept;

  assign accept = (state == IDLE) && start;
  assign rd_nxt = rd_cnt + ADDR_W'(1);

  // Gated by reset so that a reset cycle never pops data that would then be
  // lost when the pipeline is cleared at the edge.
  assign pop = reset && (state == DRAIN) && ofifo_valid && (rd_cnt < num_q);

  // Write stage: the cycle after a pop. Reset drops an in-flight write.
  assign wr_fire = reset && rd_q;

  assign ofifo_rd  = pop;
  assign pmem_cen  = ~wr_fire;
  assign pmem_wen  = ~wr_fire;
  assign pmem_addr = wr_addr;
  // Lanes pass straight through: lane i of pmem_d is lane i of psum_in.
  assign pmem_d    = wr_fire ? psum_in : d_hold;
  assign busy      = (state == DRAIN) || (state == FLUSH);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      num_q   <= '0;
      rd_cnt  <= '0;
      wr_addr <= '0;
      rd_q    <= 1'b0;
      d_hold  <= '0;
    end else begin
      rd_q <= pop;

      // Retire a write: keep its data on pmem_d and advance the address.
      // Never coincides with a start in IDLE, since the last write fires in
      // FLUSH and the FSM passes through DONE before IDLE.
      if (rd_q) begin
        d_hold  <= psum_in;
        wr_addr <= wr_addr + ADDR_W'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (num_vec != '0) begin
              state   <= DRAIN;
              num_q   <= num_vec;
              rd_cnt  <= '0;
              wr_addr <= base_addr;
            end else begin
              state <= DONE;
            end
          end
        end
        DRAIN: begin
          if (pop) begin
            rd_cnt <= rd_nxt;
            if (rd_nxt == num_q) state <= FLUSH;
          end
        end
        // Last pop's write fires during this cycle.
        FLUSH:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PSUM_DRAIN_CHECKSUM_EN
  // The final write retires on the FLUSH->DONE edge, so the value is already
  // complete when done pulses and holds until the next accepted start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (rd_q) begin
      checksum <= checksum ^ psum_in;
    end
  end
`endif

endmodule

// File: tb/tb_psum_drain.sv
// -----------------------------------------------------------------------------
// tb_psum_drain
// Directed self-checking bench for psum_drain. A small OFIFO stand-in (src_q)
// supplies vectors on pops; every SRAM write is checked against exp_q, which
// each test fills with hand-derived {address, data} pairs. Per-cycle ofifo_rd,
// write, busy and done are compared against hand-written cycle masks (bit i =
// i-th cycle after the start cycle).
// Define PSUM_DRAIN_CHECKSUM_EN to also check the checksum port.
// -----------------------------------------------------------------------------
module tb_psum_drain;

  import corelet_pkg::*;

  localparam int VW = PSUM_BW * COL;
  localparam int EW = ADDR_W + VW;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] num_vec = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              ofifo_valid = 1'b0;
  logic              ofifo_rd;
  logic [VW-1:0]     psum_in = '0;
  logic              pmem_cen;
  logic              pmem_wen;
  logic [ADDR_W-1:0] pmem_addr;
  logic [VW-1:0]     pmem_d;
  logic              busy;
  logic              done;
`ifdef PSUM_DRAIN_CHECKSUM_EN
  logic [VW-1:0]     checksum;
`endif

  always #5 clk = ~clk;

  psum_drain dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_vec     (num_vec),
    .base_addr   (base_addr),
    .ofifo_valid (ofifo_valid),
    .ofifo_rd    (ofifo_rd),
    .psum_in     (psum_in),
    .pmem_cen    (pmem_cen),
    .pmem_wen    (pmem_wen),
    .pmem_addr   (pmem_addr),
    .pmem_d      (pmem_d),
    .busy        (busy),
    .done        (done)
`ifdef PSUM_DRAIN_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  // ---------------- scoreboard ----------------
  psum_vec_t      src_q[$];
  logic [EW-1:0]  exp_q[$];
  int             n_checks = 0;
  int             n_errors = 0;
  logic           pend = 1'b0;
  psum_vec_t      pend_data = '0;
  logic           obs_rd, obs_wr, obs_busy, obs_done;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic psum_vec_t mk_vec(input int k);
    psum_vec_t v;
    for (int i = 0; i < COL; i++) v[PSUM_BW*i +: PSUM_BW] = 16'hA000 + 16'(k * 16) + 16'(i);
    return v;
  endfunction

  function automatic psum_vec_t junk();
    return VW'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [ADDR_W-1:0] n, input logic [ADDR_W-1:0] base);
    @(posedge clk); #1;
    start       = 1'b1;
    num_vec     = n;
    base_addr   = base;
    ofifo_valid = 1'b0;
    psum_in     = junk();
  endtask

  // One cycle: drive inputs just after the edge, observe mid-cycle.
  // s=1 issues a stray start with values that must be ignored.
  task automatic step(input logic v, input logic s);
    logic [EW-1:0] e;
    @(posedge clk); #1;
    psum_in     = pend ? pend_data : junk();
    start       = s;
    if (s) begin
      num_vec   = 11'h7;
      base_addr = 11'h3AA;
    end
    ofifo_valid = v;
    #2;
    obs_rd   = ofifo_rd;
    obs_wr   = !pmem_cen;
    obs_busy = busy;
    obs_done = done;
    pend     = ofifo_rd;
    if (ofifo_rd) begin
      check("pop_has_data", 256'(src_q.size() > 0), 256'(1));
      if (src_q.size() > 0) pend_data = src_q.pop_front();
      else pend_data = 'x;
    end
    if (!pmem_cen) begin
      check("wen_low", 256'(pmem_wen), 256'(0));
      check("write_expected", 256'(exp_q.size() > 0), 256'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("waddr", 256'(pmem_addr), 256'(e[EW-1:VW]));
        check("wdata", 256'(pmem_d), 256'(e[VW-1:0]));
      end
    end
  endtask

  task automatic run_pattern(input string name, input int n, input logic [15:0] vm,
                             input logic [15:0] sm, input logic [15:0] erd,
                             input logic [15:0] ewr, input logic [15:0] ebusy,
                             input logic [15:0] edone);
    for (int i = 0; i < n; i++) begin
      step(vm[i], sm[i]);
      check($sformatf("%s_c%0d_rd", name, i),   256'(obs_rd),   256'(erd[i]));
      check($sformatf("%s_c%0d_wr", name, i),   256'(obs_wr),   256'(ewr[i]));
      check($sformatf("%s_c%0d_busy", name, i), 256'(obs_busy), 256'(ebusy[i]));
      check($sformatf("%s_c%0d_done", name, i), 256'(obs_done), 256'(edone[i]));
    end
    check({name, "_all_writes"}, 256'(exp_q.size()), 256'(0));
  endtask

  task automatic load(input int k0, input int n, input logic [ADDR_W-1:0] base, input int n_exp);
    for (int i = 0; i < n; i++) src_q.push_back(mk_vec(k0 + i));
    for (int i = 0; i < n_exp; i++) exp_q.push_back({base + ADDR_W'(i), mk_vec(k0 + i)});
  endtask

  // ---------------- tests ----------------
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    psum_vec_t x;

    // Test 1: reset held two cycles with start asserted.
    start = 1'b1; num_vec = 11'd5; base_addr = 11'h123; ofifo_valid = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    check("rst_rd",   256'(ofifo_rd),  256'(0));
    check("rst_cen",  256'(pmem_cen),  256'(1));
    check("rst_wen",  256'(pmem_wen),  256'(1));
    check("rst_addr", 256'(pmem_addr), 256'(0));
    check("rst_d",    256'(pmem_d),    256'(0));
    check("rst_busy", 256'(busy),      256'(0));
    check("rst_done", 256'(done),      256'(0));
`ifdef PSUM_DRAIN_CHECKSUM_EN
    check("rst_chk",  256'(checksum),  256'(0));
`endif
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0;
    #2;
    check("post_rst_busy", 256'(busy),     256'(0));
    check("post_rst_rd",   256'(ofifo_rd), 256'(0));
    step(1'b1, 1'b0);
    check("post_rst_busy2", 256'(obs_busy), 256'(0));
    check("post_rst_done2", 256'(obs_done), 256'(0));

    // Test 2: base 0x010, 4 vectors, valid steady.
    load(1, 4, 11'h010, 4);
    do_start(11'd4, 11'h010);
    run_pattern("t2", 7, 16'h007F, 16'h0000, 16'h000F, 16'h001E, 16'h001F, 16'h0020);
    check("t2_d_held", 256'(pmem_d), 256'(mk_vec(4)));
`ifdef PSUM_DRAIN_CHECKSUM_EN
    x = '0;
    for (int i = 1; i <= 4; i++) x = x ^ mk_vec(i);
    check("t2_checksum", 256'(checksum), 256'(x));
`endif

    // Test 3: num_vec=3, valid toggling; one surplus vector stays queued.
    load(5, 4, 11'h100, 3);
    do_start(11'd3, 11'h100);
    run_pattern("t3", 8, 16'h00F5, 16'h0000, 16'h0015, 16'h002A, 16'h003F, 16'h0040);
    check("t3_surplus", 256'(src_q.size()), 256'(1));
    src_q.delete();

    // Test 4: address wrap from 0x7FE.
    load(9, 4, 11'h7FE, 0);
    exp_q.push_back({11'h7FE, mk_vec(9)});
    exp_q.push_back({11'h7FF, mk_vec(10)});
    exp_q.push_back({11'h000, mk_vec(11)});
    exp_q.push_back({11'h001, mk_vec(12)});
    do_start(11'd4, 11'h7FE);
    run_pattern("t4", 7, 16'h007F, 16'h0000, 16'h000F, 16'h001E, 16'h001F, 16'h0020);

    // Test 5a: num_vec=0 -> done next cycle, nothing popped or written.
    do_start(11'd0, 11'h055);
    run_pattern("t5a", 2, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001);

    // Test 5b: stray starts in DRAIN, FLUSH and DONE are ignored.
    load(13, 3, 11'h200, 3);
    do_start(11'd3, 11'h200);
    run_pattern("t5b", 6, 16'h003F, 16'h001A, 16'h0007, 16'h000E, 16'h000F, 16'h0010);

    // Test 6: reset after 2 of 5 pops, then a clean 2-vector drain.
    load(20, 5, 11'h300, 1);
    do_start(11'd5, 11'h300);
    run_pattern("t6a", 2, 16'h0003, 16'h0000, 16'h0003, 16'h0002, 16'h0003, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b0; ofifo_valid = 1'b1; psum_in = pend_data;
    #2;
    check("t6_rst_rd",  256'(ofifo_rd), 256'(0));
    check("t6_rst_cen", 256'(pmem_cen), 256'(1));
    check("t6_rst_wen", 256'(pmem_wen), 256'(1));
    @(posedge clk); #1;
    reset = 1'b1; ofifo_valid = 1'b0;
    #2;
    check("t6_after_busy", 256'(busy),      256'(0));
    check("t6_after_cen",  256'(pmem_cen),  256'(1));
    check("t6_after_done", 256'(done),      256'(0));
    check("t6_after_addr", 256'(pmem_addr), 256'(0));
    check("t6_after_d",    256'(pmem_d),    256'(0));
    pend = 1'b0;
    src_q.delete();
    load(30, 2, 11'h020, 2);
    do_start(11'd2, 11'h020);
    run_pattern("t6b", 5, 16'h001F, 16'h0000, 16'h0003, 16'h0006, 16'h0007, 16'h0008);
`ifdef PSUM_DRAIN_CHECKSUM_EN
    check("t6_checksum", 256'(checksum), 256'(mk_vec(30) ^ mk_vec(31)));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
